// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing a single W-bit ALU.
// One operation is in flight at a time: IDLE accepts, EXEC computes, RESP holds the result.
module alu_arbiter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [1:0]   req_fun0,
   input  logic [1:0]   req_fun1,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b1,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_val,
   output logic [2:0]   rsp_cc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic           last_r;
   logic           win_s;
   logic           any_s;
   logic           accept_s;
   logic [1:0]     fun_r;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic           id_r;
   logic [W+2:0]   res_s;
   logic [W-1:0]   rsp_val_r;
   logic [2:0]     rsp_cc_r;
   logic           rsp_id_r;

   // Result packed as {ZF, SF, OF, value}; carry-out is dropped by the W-bit sum.
   function automatic logic [W+2:0] alu_calc(input logic [1:0] fun,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         of;
      r  = '0;
      of = 1'b0;
      case (fun)
         2'd0: begin
            r  = a + b;
            of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         2'd1: begin
            r  = a - b;
            of = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         2'd2: begin
            r  = a & b;
            of = 1'b0;
         end
         default: begin
            r  = a ^ b;
            of = 1'b0;
         end
      endcase
      return {(r == '0), r[W-1], of, r};
   endfunction

   // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
   always_comb begin
      any_s = |req_valid;
      if (req_valid == 2'b11) begin
         win_s = ~last_r;
      end else if (req_valid[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      accept_s = (state_r == IDLE) && any_s;
      res_s    = alu_calc(fun_r, a_r, b_r);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_s) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: state_nxt_s = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode: grant is combinational in IDLE only.
   always_comb begin
      req_ready = 2'b00;
      if (accept_s) begin
         req_ready = win_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
      rsp_valid = (state_r == RESP);
      rsp_id    = rsp_id_r;
      rsp_val   = rsp_val_r;
      rsp_cc    = rsp_cc_r;
   end

   // Operand capture on acceptance and result registration in EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r    <= 1'b1;
         fun_r     <= 2'd0;
         a_r       <= '0;
         b_r       <= '0;
         id_r      <= 1'b0;
         rsp_val_r <= '0;
         rsp_cc_r  <= 3'd0;
         rsp_id_r  <= 1'b0;
      end else if (accept_s) begin
         last_r <= win_s;
         id_r   <= win_s;
         fun_r  <= win_s ? req_fun1 : req_fun0;
         a_r    <= win_s ? req_a1 : req_a0;
         b_r    <= win_s ? req_b1 : req_b0;
      end else if (state_r == EXEC) begin
         rsp_val_r <= res_s[W-1:0];
         rsp_cc_r  <= res_s[W+2:W];
         rsp_id_r  <= id_r;
      end else begin
         rsp_val_r <= rsp_val_r;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: arithmetic corners, round-robin,
// response back-pressure and asynchronous reset mid-operation.
module tb_alu_arbiter;

   localparam int W = 64;

   logic         clk;
   logic         rst_n;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [1:0]   req_fun0;
   logic [1:0]   req_fun1;
   logic [W-1:0] req_a0;
   logic [W-1:0] req_b0;
   logic [W-1:0] req_a1;
   logic [W-1:0] req_b1;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_val;
   logic [2:0]   rsp_cc;

   int n_checks;
   int n_fail;

   alu_arbiter #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_fun0  (req_fun0),
      .req_fun1  (req_fun1),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_val   (rsp_val),
      .rsp_cc    (rsp_cc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One operation from a single requester with rsp_ready high; operands are
   // scrambled right after acceptance to show they were latched.
   task automatic run_op(input string tag, input logic id, input logic [1:0] fun,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_val, input logic [2:0] exp_cc);
      @(negedge clk);
      rsp_ready = 1'b1;
      if (id) begin
         req_fun1 = fun; req_a1 = a; req_b1 = b; req_valid = 2'b10;
      end else begin
         req_fun0 = fun; req_a0 = a; req_b0 = b; req_valid = 2'b01;
      end
      #1;
      check_eq({tag, "_ready"}, {62'd0, req_ready}, id ? 64'd2 : 64'd1);
      @(negedge clk);
      check_eq({tag, "_exec_valid"}, {63'd0, rsp_valid}, 64'd0);
      req_valid = 2'b00;
      req_a0 = 64'hDEAD_BEEF_0000_0001; req_b0 = 64'h1234;
      req_a1 = 64'hDEAD_BEEF_0000_0002; req_b1 = 64'h5678;
      req_fun0 = 2'd3; req_fun1 = 2'd2;
      @(negedge clk);
      check_eq({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
      check_eq({tag, "_val"}, rsp_val, exp_val);
      check_eq({tag, "_cc"}, {61'd0, rsp_cc}, {61'd0, exp_cc});
      check_eq({tag, "_id"}, {63'd0, rsp_id}, {63'd0, id});
      @(negedge clk);
      check_eq({tag, "_done"}, {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_fun0  = 2'd0; req_fun1 = 2'd0;
      req_a0    = 64'd0; req_b0 = 64'd0;
      req_a1    = 64'd0; req_b1 = 64'd0;
      rsp_ready = 1'b0;
      #12;
      check_eq("rst_valid", {63'd0, rsp_valid}, 64'd0);
      check_eq("rst_ready", {62'd0, req_ready}, 64'd0);
      check_eq("rst_val", rsp_val, 64'd0);
      check_eq("rst_cc", {61'd0, rsp_cc}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_big", 1'b0, 2'd0, 64'd999999999, 64'd12345, 64'd1000012344, 3'b000);
      run_op("sub_zero", 1'b1, 2'd1, 64'd10, 64'd10, 64'd0, 3'b100);
      run_op("sub_neg", 1'b1, 2'd1, 64'd3, 64'd10, 64'hFFFF_FFFF_FFFF_FFF9, 3'b010);
      run_op("add_ovf", 1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 3'b011);
      run_op("sub_ovf", 1'b0, 2'd1, 64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 3'b001);
      run_op("and_op", 1'b1, 2'd2, 64'hF0F0, 64'hFF00, 64'hF000, 3'b000);
      run_op("xor_zero", 1'b0, 2'd3, 64'hAAAA, 64'hAAAA, 64'd0, 3'b100);

      // Back-pressure: requester 1 XOR held in RESP while requester 0 waits.
      @(negedge clk);
      rsp_ready = 1'b0;
      req_fun1 = 2'd3; req_a1 = 64'h0F0F; req_b1 = 64'h00FF; req_valid = 2'b10;
      @(negedge clk);
      req_valid = 2'b01;
      req_fun0 = 2'd0; req_a0 = 64'd1; req_b0 = 64'd1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_valid", {63'd0, rsp_valid}, 64'd1);
         check_eq("stall_val", rsp_val, 64'h0FF0);
         check_eq("stall_cc", {61'd0, rsp_cc}, 64'd0);
         check_eq("stall_id", {63'd0, rsp_id}, 64'd1);
         check_eq("stall_ready", {62'd0, req_ready}, 64'd0);
         @(negedge clk);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("stall_release", {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
      check_eq("stall_single", {63'd0, rsp_valid}, 64'd0);

      // Reset during EXEC discards the AND and restores the tie pointer.
      req_fun0 = 2'd2; req_a0 = 64'hF0; req_b0 = 64'h3C; req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", {63'd0, rsp_valid}, 64'd0);
      check_eq("arst_val", rsp_val, 64'd0);
      check_eq("arst_cc", {61'd0, rsp_cc}, 64'd0);
      check_eq("arst_id", {63'd0, rsp_id}, 64'd0);
      check_eq("arst_ready", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("arst_no_rsp", {63'd0, rsp_valid}, 64'd0);
      end

      // Both requesters valid throughout: grants must alternate starting at 0.
      req_fun0 = 2'd0; req_a0 = 64'd5; req_b0 = 64'd6;
      req_fun1 = 2'd3; req_a1 = 64'hFF; req_b1 = 64'h0F;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check_eq("tie_grant", {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
         @(negedge clk);
         check_eq("tie_busy", {62'd0, req_ready}, 64'd0);
         @(negedge clk);
         check_eq("tie_valid", {63'd0, rsp_valid}, 64'd1);
         check_eq("tie_id", {63'd0, rsp_id}, (k % 2 == 0) ? 64'd0 : 64'd1);
         check_eq("tie_val", rsp_val, (k % 2 == 0) ? 64'd11 : 64'hF0);
         check_eq("tie_ready_rsp", {62'd0, req_ready}, 64'd0);
         @(negedge clk);
         #1;
      end
      req_valid = 2'b00;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
